// File: rtl/multi_debouncer_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Contents:
//   db_state_e - per-channel FSM state (LOW, QUAL_HI, HIGH, QUAL_LO)
//   cnt_width  - width of the per-channel stability/repeat counter
package multi_debouncer_pkg;

  typedef enum logic [1:0] {
    StLow    = 2'd0,
    StQualHi = 2'd1,
    StHigh   = 2'd2,
    StQualLo = 2'd3
  } db_state_e;

  // Counter must hold the largest terminal count of any mode.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles,
                                            input int unsigned repeat_delay,
                                            input int unsigned repeat_period);
    int unsigned m;
    m = stable_cycles;
    if (repeat_delay > m) m = repeat_delay;
    if (repeat_period > m) m = repeat_period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/multi_debouncer_channel.sv
// One debouncer channel: synchroniser chain, stability counter and state machine.
// Optional auto-repeat of rise while held, enabled by MULTI_DEBOUNCER_REPEAT_EN.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   raw   - raw asynchronous input
//   level - debounced level
//   rise  - one-cycle pulse on accepted 0->1 (and auto-repeat pulses)
//   fall  - one-cycle pulse on accepted 1->0
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 128,
  parameter int unsigned REPEAT_DELAY  = 4096,
  parameter int unsigned REPEAT_PERIOD = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntZero = '0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

`ifdef MULTI_DEBOUNCER_REPEAT_EN
  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);
  // Set once the first repeat has fired; selects the period instead of the delay.
  logic rep_q, rep_d;
`endif

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= StLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef MULTI_DEBOUNCER_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef MULTI_DEBOUNCER_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef MULTI_DEBOUNCER_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      StLow: begin
        if (s) begin
          state_d = StQualHi;
          cnt_d   = CntOne;
        end
      end
      StQualHi: begin
        if (!s) begin
          state_d = StLow;
          cnt_d   = CntZero;
        end else if (cnt_q == StableLast) begin
          state_d = StHigh;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = CntZero;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHigh: begin
        if (!s) begin
          state_d = StQualLo;
          cnt_d   = CntOne;
`ifdef MULTI_DEBOUNCER_REPEAT_EN
          rep_d   = 1'b0;
        end else if (cnt_q == (rep_q ? PeriodLast : DelayLast)) begin
          rise_d = 1'b1;
          rep_d  = 1'b1;
          cnt_d  = CntZero;
        end else begin
          cnt_d = cnt_q + CntOne;
`endif
        end
      end
      StQualLo: begin
        if (s) begin
          state_d = StHigh;
          cnt_d   = CntZero;
        end else if (cnt_q == StableLast) begin
          state_d = StLow;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = CntZero;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = CntZero;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/multi_debouncer.sv
// N-channel debouncer for buttons and switches.
// Optional auto-repeat of rise pulses while held: define MULTI_DEBOUNCER_REPEAT_EN.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset
//   in       - raw asynchronous inputs, one per channel
//   level    - debounced levels
//   rise     - one-cycle pulses on accepted presses (and auto-repeats)
//   fall     - one-cycle pulses on accepted releases
//   any_rise - registered OR of rise, one cycle after rise
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 128,
  parameter int unsigned REPEAT_DELAY  = 4096,
  parameter int unsigned REPEAT_PERIOD = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_rise
);

  logic any_rise_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (in[g]),
      .level(level[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_rise_q <= 1'b0;
    end else begin
      any_rise_q <= |rise;
    end
  end

  assign any_rise = any_rise_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: directed scenarios with literal
// expectations plus randomized stimulus checked every cycle against a
// sliding-window model of the debounce rules.
module tb_multi_debouncer;

  localparam int unsigned CH = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned SC = 4;
  localparam int unsigned RD = 16;
  localparam int unsigned RP = 8;
`ifdef MULTI_DEBOUNCER_REPEAT_EN
  localparam int ExpRepeats = 5;
`else
  localparam int ExpRepeats = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] in;
  logic [CH-1:0] level, rise, fall;
  logic          any_rise;

  always #5 clk = ~clk;

  multi_debouncer #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .any_rise(any_rise)
  );

  int checks = 0;
  int errors = 0;

  // Model state: raw-input delay line, window of synchronised samples, outputs.
  logic [CH-1:0] inq [SS];
  logic [CH-1:0] sq  [SC];
  logic [CH-1:0] m_level = '0, m_rise = '0, m_fall = '0, prev_s = '0;
  logic          m_any = 1'b0;
  int            hold [CH];
  bit            chk_en = 1'b0;
  int            rise_cnt [CH];

  task automatic model_step();
    logic [CH-1:0] s_now;
    bit all1, all0;
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) inq[i] = '0;
      for (int i = 0; i < SC; i++) sq[i] = '0;
      m_level = '0; m_rise = '0; m_fall = '0; m_any = 1'b0; prev_s = '0;
      for (int c = 0; c < CH; c++) hold[c] = 0;
      chk_en = 1'b1;
      return;
    end
    s_now = inq[SS-1];
    for (int i = SS - 1; i > 0; i--) inq[i] = inq[i-1];
    inq[0] = in;
    for (int i = SC - 1; i > 0; i--) sq[i] = sq[i-1];
    sq[0] = s_now;
    m_any  = |m_rise;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < CH; c++) begin
      all1 = 1'b1;
      all0 = 1'b1;
      for (int k = 0; k < SC; k++) begin
        if (sq[k][c]) all0 = 1'b0;
        else all1 = 1'b0;
      end
      if (!m_level[c] && all1) begin
        m_level[c] = 1'b1;
        m_rise[c]  = 1'b1;
        hold[c]    = 0;
      end else if (m_level[c] && all0) begin
        m_level[c] = 1'b0;
        m_fall[c]  = 1'b1;
      end else if (m_level[c]) begin
        // Held-high samples since acceptance or since returning from a dip.
        if (s_now[c] && prev_s[c]) begin
          hold[c]++;
`ifdef MULTI_DEBOUNCER_REPEAT_EN
          if (hold[c] == RD || (hold[c] > RD && (hold[c] - RD) % RP == 0)) m_rise[c] = 1'b1;
`endif
        end else begin
          hold[c] = 0;
        end
      end
    end
    prev_s = s_now;
  endtask

  always @(posedge clk) model_step();

  task automatic check_vec(input string name, input logic [CH-1:0] act,
                           input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_vec("level", level, m_level);
      check_vec("rise", rise, m_rise);
      check_vec("fall", fall, m_fall);
      check_vec("any_rise", CH'(any_rise), CH'(m_any));
      for (int c = 0; c < CH; c++) begin
        if (rise[c] === 1'b1 && fall[c] === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL rise_and_fall ch=%0d t=%0t actual=both required=one", c, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) if (rise[c] === 1'b1) rise_cnt[c]++;
  end

  int n0;
  int hold_left [CH];

  initial begin
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c]  = 0;
      hold_left[c] = 0;
    end
    // 1: reset with inputs high, then idle low.
    rst_n = 1'b0;
    in    = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    in = '0;
    repeat (20) @(negedge clk);
    lit("idle_level", int'(level), 0);
    lit("idle_pulses", int'(rise) + int'(fall) + int'(any_rise), 0);

    // 2: press on channel 0, accept latency, then auto-repeat window.
    #1 in[0] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    lit("press_level0", int'(level[0]), 1);
    lit("press_rise0", int'(rise[0]), 1);
    lit("model_rise0", int'(m_rise[0]), 1);
    @(negedge clk);
    lit("press_rise0_off", int'(rise[0]), 0);
    lit("press_any_rise", int'(any_rise), 1);
    n0 = rise_cnt[0];
    repeat (49) @(negedge clk);
    lit("repeat_count0", rise_cnt[0] - n0, ExpRepeats);
    #1 in[0] = 1'b0;
    repeat (6) @(negedge clk);
    lit("release_fall0", int'(fall[0]), 1);
    lit("release_rise0", int'(rise[0]), 0);
    @(negedge clk);
    lit("release_level0", int'(level[0]), 0);

    // 3: short glitch on channel 1, then a press with a one-cycle dip.
    n0 = rise_cnt[1];
    #1 in[1] = 1'b1;
    repeat (3) @(negedge clk);
    #1 in[1] = 1'b0;
    repeat (12) @(negedge clk);
    lit("glitch_rise1", rise_cnt[1] - n0, 0);
    lit("glitch_level1", int'(level[1]), 0);
    n0 = rise_cnt[1];
    #1 in[1] = 1'b1;
    repeat (10) @(negedge clk);
    #1 in[1] = 1'b0;
    @(negedge clk);
    #1 in[1] = 1'b1;
    repeat (10) @(negedge clk);
    lit("dip_rise1", rise_cnt[1] - n0, 1);
    #1 in[1] = 1'b0;
    repeat (12) @(negedge clk);

    // 4: press and release channel 2, fall six edges after release.
    #1 in[2] = 1'b1;
    repeat (10) @(negedge clk);
    #1 in[2] = 1'b0;
    repeat (5) @(negedge clk);
    lit("fall2_early", int'(fall[2]), 0);
    @(negedge clk);
    lit("fall2", int'(fall[2]), 1);
    lit("fall2_no_rise", int'(rise[2]), 0);
    @(negedge clk);
    lit("fall2_off", int'(fall[2]), 0);
    lit("level2_after", int'(level[2]), 0);

    // 5: simultaneous presses, then reset during qualification.
    #1 in = 4'b1001;
    repeat (6) @(negedge clk);
    lit("simul_rise", int'(rise), 9);
    #1 in = '0;
    repeat (12) @(negedge clk);
    #1 in[1] = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    in = '0;
    @(negedge clk);
    lit("rst_outputs", int'(level) + int'(rise) + int'(fall) + int'(any_rise), 0);
    #1 rst_n = 1'b1;
    n0 = rise_cnt[1];
    repeat (12) @(negedge clk);
    lit("rst_abort_rise1", rise_cnt[1] - n0, 0);

    // Randomized phase: per-channel hold times, occasional reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      #1;
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < CH; c++) begin
        if (hold_left[c] == 0) begin
          in[c] = ~in[c];
          hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 40));
        end else begin
          hold_left[c]--;
        end
      end
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised N-channel debouncer for buttons and switches.
- Each channel has its own synchroniser, a stability counter and a small FSM.
- Outputs per channel: a debounced level, a one-cycle press pulse and a one-cycle release pulse.
- Sits between board I/O pins and user logic such as UART triggers, menu FSMs and LED demos.

Parameters:
- CHANNELS, 4: number of independent inputs (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- STABLE_CYCLES, 128: consecutive identical synchronised samples needed to accept a change (>=2).
- REPEAT_DELAY, 4096: cycles of held press before the first auto-repeat pulse. Used only with REPEAT_EN.
- REPEAT_PERIOD, 1024: cycles between later auto-repeat pulses (>=2). Used only with REPEAT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in  in  CHANNELS  raw asynchronous inputs.
- level  out  CHANNELS  debounced level per channel.
- rise  out  CHANNELS  one-cycle pulse on accepted 0->1; also auto-repeat pulses.
- fall  out  CHANNELS  one-cycle pulse on accepted 1->0.
- any_rise  out  1  registered OR of rise, one cycle later than rise.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Sync chains, counters, level, rise, fall and any_rise all become 0.
  - Every channel FSM goes to LOW.
  - A raw input already high at reset release is debounced as a normal press.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- s = last synchroniser stage. cnt width = $clog2(max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
- FSM states, and transitions evaluated each edge:
  - LOW: if s=1, go to QUAL_HI with cnt<=1.
  - QUAL_HI:
    - s=0: go to LOW, cnt<=0, no pulse.
    - s=1 and cnt==STABLE_CYCLES-1: go to HIGH, level<=1, rise<=1, cnt<=0.
    - otherwise: cnt<=cnt+1.
  - HIGH: if s=0, go to QUAL_LO with cnt<=1.
  - QUAL_LO: mirror of QUAL_HI.
    - s=1: back to HIGH with no pulse.
    - Completing the count: go to LOW, level<=0, fall<=1.
- Latency:
  - Edge 1 is the first edge that samples raw in high.
  - level and rise update on edge SYNC_STAGES+STABLE_CYCLES.
  - Release is symmetric.
- rise and fall are high for exactly one cycle, never both in the same cycle for one channel.
- A glitch shorter than STABLE_CYCLES synchronised samples produces no pulse and no level change.
- The counter never wraps. It is cleared on every state change and on any qualification failure.
- Reset mid-qualification aborts with no pulse.

Optional Feature:
- Macro: MULTI_DEBOUNCER_REPEAT_EN.
- When defined:
  - In HIGH with s=1, cnt counts.
  - On reaching REPEAT_DELAY, rise pulses once and cnt<=0.
  - From then on, rise pulses every REPEAT_PERIOD cycles while held.
  - Entering QUAL_LO stops repeats.
  - Returning from QUAL_LO to HIGH restarts the REPEAT_DELAY wait.
- When undefined: exactly one rise per accepted press. The repeat counter logic is absent.

Decomposition:
- Package multi_debouncer_pkg holds:
  - the state enum type (LOW, QUAL_HI, HIGH, QUAL_LO, 2 bits);
  - a constant function for counter width.
- Sub-module debounce_channel holds one sync chain, counter and FSM.
- Top generates CHANNELS instances and the any_rise register.

Test Plan (CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8):
1. Hold rst_n=0 with in=4'b1111, release, keep in=0 for 20 cycles -> level, rise, fall and any_rise stay 0.
2. in[0] 0->1 before edge 1, held -> level[0]=1 and rise[0]=1 after edge 6; rise[0]=0 after edge 7; any_rise=1 after edge 7.
3. in[1] high for 3 cycles then low -> no rise[1] and level[1] stays 0. Repeat with a 1-cycle low dip during a press -> exactly one rise[1].
4. Press then release in[2] -> fall[2] one cycle, 6 edges after release. level[2]=0 afterwards. No rise in the same cycle.
5. in[0] and in[3] rise in the same cycle -> rise=4'b1001 in a single cycle. Pull rst_n low mid-qualification on in[1] -> no pulse; all outputs 0 on the next edge.
6. With MULTI_DEBOUNCER_REPEAT_EN, hold in[0] for 50 cycles after acceptance -> extra rise[0] pulses 16, 24, 32, 40 and 48 cycles after the initial pulse. Without the macro -> no extra pulses.
